// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode constants
package mips_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SA_LSB = 6;
  localparam int TGT_W = 26;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: priority operand forwarding selector, source 0 wins
module fwd_mux
  import mips_pkg::*;
#(
  parameter int NUM_FW = 2,
  parameter int XLEN = XLEN_DEF
) (
  input  logic [4:0]           reg_addr,
  input  logic [XLEN-1:0]      reg_data,
  input  logic [NUM_FW-1:0]    fw_wr_en,
  input  logic [5*NUM_FW-1:0]  fw_wr_addr,
  input  logic [XLEN*NUM_FW-1:0] fw_data,
  output logic [XLEN-1:0]      data
);
  // scan oldest to youngest so the lowest matching index overrides; r0 is hardwired zero
  always_comb begin
    data = reg_data;
    for (int i = NUM_FW - 1; i >= 0; i--)
      if (fw_wr_en[i] && fw_wr_addr[5*i +: 5] == reg_addr) data = fw_data[XLEN*i +: XLEN];
    if (reg_addr == REG_ZERO) data = '0;
  end
endmodule

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: MIPS decode stage with forwarding, load-use interlock and stall counter
module id_stage_fwd
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NUM_FW = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr_if_r,
  input  logic [XLEN-1:0]        pc_plus_1_if_r,
  input  logic                   valid_if_r,
  output logic [4:0]             reg_ra_a,
  output logic [4:0]             reg_ra_b,
  input  logic [XLEN-1:0]        reg_rd_a,
  input  logic [XLEN-1:0]        reg_rd_b,
  input  logic [NUM_FW-1:0]      fw_wr_en,
  input  logic [5*NUM_FW-1:0]    fw_wr_addr,
  input  logic [XLEN*NUM_FW-1:0] fw_data,
  input  logic                   sext_sel_id,
  input  logic                   reg_wr_addr_rt_sel,
  input  logic                   reg_wr_en_id,
  input  logic                   mem_rd_id,
  input  logic                   uses_rs,
  input  logic                   uses_rt,
  input  logic                   hold_id,
  input  logic                   flush_id,
  output logic                   stall_id,
  output logic [XLEN-1:0]        reg_a_id_r,
  output logic [XLEN-1:0]        reg_b_id_r,
  output logic [XLEN-1:0]        imm_ext_id_r,
  output logic [XLEN-1:0]        pc_plus_1_id_r,
  output logic [4:0]             reg_wr_addr_id_r,
  output logic [4:0]             sa_id_r,
  output logic                   reg_wr_en_id_r,
  output logic                   mem_rd_id_r,
  output logic                   valid_id_r,
  output logic [XLEN-1:0]        beq_bne_addr_id,
  output logic [XLEN-1:0]        jr_addr_id,
  output logic [XLEN-1:0]        jal_j_addr_id,
  output logic                   rd_a_equ_rd_b_id,
  output logic [CNT_W-1:0]       stall_cnt
);
  logic [4:0] rs, rt, rd, sa, dest;
  logic [15:0] imm;
  logic [XLEN-1:0] imm_ext, fwd_a, fwd_b;
  logic ld;
  logic unused_op;
  assign rs = instr_if_r[RS_LSB +: 5];
  assign rt = instr_if_r[RT_LSB +: 5];
  assign rd = instr_if_r[RD_LSB +: 5];
  assign sa = instr_if_r[SA_LSB +: 5];
  assign imm = instr_if_r[15:0];
  assign unused_op = ^instr_if_r[31:TGT_W];
  assign imm_ext = {{(XLEN-16){sext_sel_id & imm[15]}}, imm};
  assign dest = reg_wr_addr_rt_sel ? rt : rd;
  assign reg_ra_a = rs;
  assign reg_ra_b = rt;
  fwd_mux #(.NUM_FW(NUM_FW), .XLEN(XLEN)) u_fwd_a (
    .reg_addr(rs), .reg_data(reg_rd_a), .fw_wr_en(fw_wr_en),
    .fw_wr_addr(fw_wr_addr), .fw_data(fw_data), .data(fwd_a)
  );
  fwd_mux #(.NUM_FW(NUM_FW), .XLEN(XLEN)) u_fwd_b (
    .reg_addr(rt), .reg_data(reg_rd_b), .fw_wr_en(fw_wr_en),
    .fw_wr_addr(fw_wr_addr), .fw_data(fw_data), .data(fwd_b)
  );
  assign beq_bne_addr_id = pc_plus_1_if_r + (imm_ext << 2);
  assign jr_addr_id = fwd_a;
  assign jal_j_addr_id = {pc_plus_1_if_r[XLEN-1:28], instr_if_r[TGT_W-1:0], 2'b00};
  assign rd_a_equ_rd_b_id = fwd_a == fwd_b;
  assign stall_id = valid_if_r & valid_id_r & mem_rd_id_r & (reg_wr_addr_id_r != REG_ZERO)
                  & ((uses_rs & (rs == reg_wr_addr_id_r)) | (uses_rt & (rt == reg_wr_addr_id_r))) & ~hold_id;
  assign ld = valid_if_r & ~flush_id & ~stall_id;
  // pipeline register: flush and stall both load data but kill the control bits; hold freezes
  always_ff @(posedge clk)
    if (!rst) begin
      reg_a_id_r <= '0;
      reg_b_id_r <= '0;
      imm_ext_id_r <= '0;
      pc_plus_1_id_r <= '0;
      reg_wr_addr_id_r <= '0;
      sa_id_r <= '0;
      reg_wr_en_id_r <= 1'b0;
      mem_rd_id_r <= 1'b0;
      valid_id_r <= 1'b0;
    end else if (flush_id || !hold_id) begin
      reg_a_id_r <= fwd_a;
      reg_b_id_r <= fwd_b;
      imm_ext_id_r <= imm_ext;
      pc_plus_1_id_r <= pc_plus_1_if_r;
      reg_wr_addr_id_r <= dest;
      sa_id_r <= sa;
      reg_wr_en_id_r <= ld & reg_wr_en_id;
      mem_rd_id_r <= ld & mem_rd_id;
      valid_id_r <= ld;
    end
  // saturating count of interlock cycles
  always_ff @(posedge clk)
    if (!rst) stall_cnt <= '0;
    else if (stall_id && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: doc/id_stage_fwd.md
# id_stage_fwd

Parametrised decode stage for the 5-stage MIPS pipeline, sitting between the IF pipeline register and the EXE stage. It decodes rs/rt/rd/sa/imm/target, reads the register file, and resolves operands through NUM_FW prioritised forwarding sources. It detects load-use hazards and inserts bubbles, and supports downstream hold, flush and a valid bit. It also provides forwarded branch compare and jump targets to pc_gen, and counts stall cycles for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- NUM_FW, 2, number of forwarding sources; range 1..4. Index 0 has the highest priority (youngest producer).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; single clock, synchronous, active-low.
- instr_if_r  in  32  instruction from IF.
- pc_plus_1_if_r  in  XLEN  PC+4 from IF.
- valid_if_r  in  1  IF slot holds a real instruction.
- reg_ra_a / reg_ra_b  out  5  register-file read addresses; equal to rs / rt.
- reg_rd_a / reg_rd_b  in  XLEN  register-file read data.
- fw_wr_en  in  NUM_FW  forwarding source i writes a register.
- fw_wr_addr  in  5*NUM_FW  destination register of source i; slice [5i+4:5i].
- fw_data  in  XLEN*NUM_FW  result of source i.
- sext_sel_id, reg_wr_addr_rt_sel, reg_wr_en_id, mem_rd_id, uses_rs, uses_rt  in  1 each  decode controls from ctrl.
- hold_id  in  1  downstream stall; all ID registers hold their values.
- flush_id  in  1  squash the instruction entering EXE.
- stall_id  out  1  load-use interlock; IF/PC must hold.
- reg_a_id_r, reg_b_id_r, imm_ext_id_r, pc_plus_1_id_r  out  XLEN  registered operands to EXE.
- reg_wr_addr_id_r, sa_id_r  out  5  registered to EXE.
- reg_wr_en_id_r, mem_rd_id_r, valid_id_r  out  1  registered to EXE.
- beq_bne_addr_id, jr_addr_id, jal_j_addr_id  out  XLEN  combinational next-PC candidates.
- rd_a_equ_rd_b_id  out  1  forwarded rs == rt.
- stall_cnt  out  CNT_W  saturating count of stall_id cycles.

## Operation
- Field extraction: rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], imm=[15:0], target=[25:0].
- Immediate extension: imm_ext = {(XLEN-16){sext_sel_id & imm[15]}, imm}.
- Operand resolution, for each of rs and rt:
  - Register 0 always resolves to 0.
  - Otherwise, use fw_data[i] for the lowest i with fw_wr_en[i] and fw_wr_addr[i] == reg.
  - If no source matches, use reg_rd_x.
- Branch and jump targets:
  - beq_bne_addr_id = pc_plus_1_if_r + (imm_ext << 2), modulo 2^XLEN.
  - jr_addr_id = forwarded rs.
  - jal_j_addr_id = {pc_plus_1_if_r[XLEN-1:28], target, 2'b00}.
- Branch compare: rd_a_equ_rd_b_id = (fwd_a == fwd_b).
- Load-use hazard: stall_id = valid_if_r & valid_id_r & mem_rd_id_r & (reg_wr_addr_id_r != 0) & ((uses_rs & rs == reg_wr_addr_id_r) | (uses_rt & rt == reg_wr_addr_id_r)) & ~hold_id.
- Destination selection: dest = reg_wr_addr_rt_sel ? rt : rd.

## Timing
- Reset (rst == 0 at a clk edge): every registered output and stall_cnt go to 0, including valid_id_r = 0. Reset applied mid-stall clears the stall on the next edge.
- Register update priority at each edge:
  1. Reset.
  2. flush_id: valid_id_r, reg_wr_en_id_r and mem_rd_id_r go to 0; data registers take the new values. Flush beats hold.
  3. hold_id: all registers keep their values.
  4. stall_id: bubble; valid_id_r, reg_wr_en_id_r and mem_rd_id_r go to 0, and data registers load normally.
  5. Otherwise, normal load. valid_id_r takes valid_if_r, and reg_wr_en_id_r / mem_rd_id_r are qualified by valid_if_r.
- Latency: IF to EXE register takes 1 cycle. Combinational outputs change in the same cycle as their inputs.
- A load followed by a dependent instruction gives exactly 1 stall cycle. On the next cycle the load has left ID, so the hazard clears and the MEM-stage forward supplies the value.
- stall_cnt increments on every edge where stall_id = 1, saturates at 2^CNT_W-1, and clears only on reset.
- When hold_id and a hazard occur together, stall_id = 0, because IF is already held by the global stall.

## Structure
- Shared package mips_pkg holds the field bit positions, the REG_ZERO constant, and the XLEN default.
- One sub-module, fwd_mux: a parametrised priority forwarding selector (NUM_FW, XLEN), instantiated twice (rs and rt).

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs. After release all outputs are 0 and stall_cnt = 0.
- Forward priority: rs=5, fw_wr_en=2'b11, both fw_wr_addr=5, fw_data={0xBBBB, 0xAAAA}, reg_rd_a=0x1234. Expect jr_addr_id = 0xAAAA and, next cycle, reg_a_id_r = 0xAAAA. Repeat with rs=0; expect 0.
- Load-use: a lw writing r8 in ID, followed by add using r8 as rt. Expect stall_id = 1 for one cycle, valid_id_r = 0 on the bubble, then the add issues; stall_cnt = 1.
- Branch compare: rs=3, rt=4, fw source 1 writes r4 = 0x10, reg_rd_a = 0x10. Expect rd_a_equ_rd_b_id = 1. With imm = 0xFFFF, sext_sel=1 and pc_plus_1 = 0x100, expect beq_bne_addr_id = 0xFC.
- Hold vs flush: hold_id=1 for 3 cycles keeps the outputs stable. hold_id=1 with flush_id=1 gives valid_id_r = 0 on the next edge.
- Saturation: CNT_W=2 with continuous hazards gives stall_cnt sequence 1, 2, 3, 3.
